// File: rtl/serial_negate_ctrl_if.sv
// Parallel request/response bundle between a producer/consumer and serial_negate_ctrl.
interface serial_negate_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             overflow;

  modport master (
    output start,
    output din,
    input  busy,
    input  done,
    input  dout,
    input  overflow
  );

  modport slave (
    input  start,
    input  din,
    output busy,
    output done,
    output dout,
    output overflow
  );
endinterface

// File: rtl/serial_negate_ctrl.sv
// Negates a parallel word by streaming it LSB-first through an external serial
// two's-complement complementer and reassembling the serial result.
module serial_negate_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_negate_ctrl_if.slave  bus,
  output logic                 cmp_areset,
  output logic                 cmp_x,
  input  logic                 cmp_z
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal  = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StClr, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] res_q;
  logic [CntW-1:0]  cnt_q;
  logic             ovf_pend_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] dout_q;
  logic             overflow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      shreg_q    <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dout_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            shreg_q    <= bus.din;
            ovf_pend_q <= (bus.din == MinVal);
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= StClr;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StClr: begin
          state_q <= StShift;
        end
        StShift: begin
          shreg_q <= shreg_q >> 1;
          res_q   <= {cmp_z, res_q[WIDTH-1:1]};
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            // Publish the result together with the final serial bit.
            dout_q     <= {cmp_z, res_q[WIDTH-1:1]};
            overflow_q <= ovf_pend_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= StDone;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // The complementer must be cleared before bit 0 and whenever we are in reset.
  assign cmp_areset   = reset | (state_q == StClr);
  assign cmp_x        = (state_q == StShift) & shreg_q[0];

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.dout     = dout_q;
  assign bus.overflow = overflow_q;

endmodule

// File: doc/serial_negate_ctrl.md
# serial_negate_ctrl

Sequencer that negates a parallel two's-complement word by streaming it LSB-first through the team's serial two's-complement Mealy complementer, then reassembles the serial result into a parallel word. It sits between a parallel producer/consumer and one external complementer instance. It owns that instance's reset and input bit, and samples its output bit.

## Interface
- WIDTH, 8, word width in bits; legal range ≥ 2.
- clk  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  request; sampled only in IDLE or DONE.
- din  in  WIDTH  operand; captured on the edge that accepts start.
- busy  out  1  high in CLR and SHIFT.
- done  out  1  one-cycle pulse; dout/overflow valid this cycle.
- dout  out  WIDTH  negated result (−din mod 2^WIDTH); held until the next accepted start.
- overflow  out  1  din was 1 followed by WIDTH−1 zeros (negation unrepresentable); held with dout.
- cmp_areset  out  1  drives the complementer's async reset.
- cmp_x  out  1  serial bit to the complementer.
- cmp_z  in  1  complementer's combinational Mealy output for the current cmp_x.

## Operation
- Complementer contract: z = x XOR (a 1 was seen since reset); its state updates on clk and clears asynchronously on cmp_areset.
- FSM states: IDLE, CLR, SHIFT, DONE; reset value is IDLE.
- IDLE: if start=1, then shreg<=din, overflow<=(din==1<<(WIDTH−1)), cnt<=0, and the FSM goes to CLR. Otherwise it stays in IDLE.
- CLR: lasts exactly one cycle, then the FSM goes to SHIFT.
- SHIFT: cmp_x=shreg[0].
  - Each edge: shreg shifts right; res<={cmp_z, res[WIDTH−1:1]}; cnt increments.
  - When cnt==WIDTH−1 on an edge, the FSM goes to DONE.
  - dout is res.
- DONE: lasts one cycle with done=1.
  - start=1 here is accepted exactly as in IDLE (capture, go to CLR).
  - Otherwise the FSM goes to IDLE.
- start in CLR/SHIFT is ignored with no side effects; din is not re-sampled.
- cmp_areset = reset OR (state==CLR), combinational. This guarantees the complementer is cleared before bit 0 and during any reset.
- cmp_x = 0 outside SHIFT.
- Reset values: busy=0, done=0, dout=0, overflow=0, cmp_x=0, cmp_areset=1 while reset is high.
- Reset mid-operation: the FSM goes to IDLE on that edge, and the partial result is discarded (dout=0).
- Arithmetic: result is exact modulo 2^WIDTH. 0 maps to 0. 100…0 maps to 100…0 with overflow=1.

## Timing
- Start accepted at edge E0.
- CLR is the cycle after E0; SHIFT is the cycles after E1 … E(WIDTH).
- done=1 in the cycle after edge E(WIDTH+1); total latency is WIDTH+1 cycles from the accepting edge to done.
- busy=1 for WIDTH+1 cycles.
- Throughput: back-to-back (start held high) gives one result per WIDTH+2 cycles. DONE and the next CLR are adjacent; there is no idle cycle.
- The dout/overflow update is registered and becomes visible in the same cycle done rises.
- cnt needs clog2(WIDTH) bits.

## Test plan
- WIDTH=8, din=8'h01, start pulse: done exactly 9 cycles after the accepting edge, dout=8'hFF, overflow=0, busy high 9 cycles.
- din=8'h6C: dout=8'h94. din=8'h00: dout=8'h00. Each with overflow=0.
- din=8'h80: dout=8'h80, overflow=1. A following din=8'h7F: dout=8'h81, overflow=0.
- start re-pulsed with din=8'h55 during SHIFT: ignored; the in-flight result is unchanged and no extra done appears.
- start held high with din alternating 8'h01/8'h02: done every 10 cycles, dout=8'hFF then 8'hFE, busy drops only during DONE.
- reset asserted on the 4th SHIFT cycle: next cycle is IDLE with busy=0, dout=0, cmp_areset=1 during reset. A subsequent din=8'h03 yields 8'hFD, proving the complementer was cleared.
